// File: rtl/sram_ctrl_pkg.sv
// Shared widths and types for the single-port SRAM arbiter and its response FIFOs.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W    = 10;
    localparam int SRAM_DATA_W    = 38;
    localparam int SRAM_RSP_DEPTH = 2;

    typedef logic port_idx_t;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous response FIFO; storage is reset so the head reads 0 when empty after reset.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int DEPTH  = SRAM_RSP_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/sram1rw_arbiter.sv
// Round-robin arbiter for two clients sharing one 1RW SRAM macro, with per-port read-response FIFOs.
module sram1rw_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RSP_DEPTH = SRAM_RSP_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              sram_ce,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    sram_req_t         w_req [2];
    sram_req_t         w_gnt_req;
    logic [1:0]        w_valid;
    logic [1:0]        w_rsp_ready;
    logic [1:0]        w_pop;
    logic [1:0]        w_push;
    logic [1:0]        w_full;
    logic [1:0]        w_empty;
    logic [1:0]        w_elig;
    logic [1:0]        w_grant;
    logic [CNT_W-1:0]  w_count [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic [2:0]        w_occ   [2];
    logic              w_any;
    port_idx_t         w_sel;

    logic              r_rd_inflight;
    port_idx_t         r_rd_port;
    port_idx_t         r_rr_ptr;

    assign w_req[0]    = '{we: p0_req_we, addr: p0_req_addr, wdata: p0_req_wdata};
    assign w_req[1]    = '{we: p1_req_we, addr: p1_req_addr, wdata: p1_req_wdata};
    assign w_valid     = {p1_req_valid, p0_req_valid};
    assign w_rsp_ready = {p1_rsp_ready, p0_rsp_ready};

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        // Occupancy counts the read already in the macro pipe, and credits a pop happening now.
        assign w_pop[gi]  = w_rsp_ready[gi] & ~w_empty[gi];
        assign w_push[gi] = r_rd_inflight && (r_rd_port == port_idx_t'(gi));
        assign w_occ[gi]  = 3'(w_push[gi]) + 3'(w_count[gi]) - 3'(w_pop[gi]);
        assign w_elig[gi] = w_valid[gi] &
                            (w_req[gi].we | ((w_occ[gi] < 3'(RSP_DEPTH)) & ~(w_full[gi] & ~w_pop[gi])));

        sram_rsp_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (RSP_DEPTH)
        ) u_rsp_fifo (
            .i_clk   (clock),
            .i_rst_n (reset_n),
            .i_push  (w_push[gi]),
            .i_wdata (sram_o),
            .i_pop   (w_pop[gi]),
            .o_rdata (w_rdata[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi]),
            .o_count (w_count[gi])
        );
    end

    // Reset gates the grant combinationally so the macro is deselected the moment reset asserts.
    assign w_any     = reset_n & (|w_elig);
    assign w_sel     = (&w_elig) ? r_rr_ptr : port_idx_t'(w_elig[1]);
    assign w_grant   = w_any ? (2'b01 << w_sel) : 2'b00;
    assign w_gnt_req = w_req[w_sel];

    assign p0_req_ready = w_grant[0];
    assign p1_req_ready = w_grant[1];
    assign p0_rsp_valid = ~w_empty[0];
    assign p1_rsp_valid = ~w_empty[1];
    assign p0_rsp_rdata = w_rdata[0];
    assign p1_rsp_rdata = w_rdata[1];

    assign sram_ce  = clock;
    assign sram_csb = ~w_any;
    assign sram_web = ~(w_any & w_gnt_req.we);
    assign sram_oeb = ~(w_any & ~w_gnt_req.we);
    assign sram_a   = w_any ? w_gnt_req.addr  : '0;
    assign sram_i   = w_any ? w_gnt_req.wdata : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr      <= 1'b0;
            r_rd_inflight <= 1'b0;
            r_rd_port     <= 1'b0;
        end else begin
            if (w_any) begin
                r_rr_ptr <= ~w_sel;
            end
            r_rd_inflight <= w_any & ~w_gnt_req.we;
            r_rd_port     <= w_sel;
        end
    end

endmodule
